// File: rtl/spi_slave_rx_if.sv
// Received-word handshake between spi_slave_rx and its consumer.
interface spi_slave_rx_if #(
  parameter int DATA_SIZE = 9
);
  logic [DATA_SIZE-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready
  );
endinterface

// File: rtl/spi_slave_rx.sv
// SPI slave receiver: {dc, data} words out on a valid/ready handshake.
// Define SPI_SLAVE_RX_FIFO_EN for a FIFO_DEPTH-entry output FIFO.
module spi_slave_rx #(
  parameter int DATA_SIZE   = 9,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           spi_sck,
  input  logic           spi_mosi,
  input  logic           spi_dc,
  input  logic           spi_cs,
  spi_slave_rx_if.master rx,
  output logic           overflow,
  output logic           frame_err,
  output logic           busy
);
  localparam int SW = DATA_SIZE - 1;
  localparam int CW = $clog2(DATA_SIZE);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic [SYNC_STAGES-1:0] dc_sync_q, dc_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic sck_prev_q, sck_prev_d;
  logic cs_prev_q, cs_prev_d;
  logic sck_s, mosi_s, dc_s, cs_act;
  logic sck_rise, cs_rise;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [SW-1:0]  shift_q, shift_d;
  logic           dc_q, dc_d;
  logic           ferr_q, ferr_d;
  logic           ovf_q, ovf_d;
  logic           push;
  logic           pop;
  logic [DATA_SIZE-1:0] word;

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign dc_s     = dc_sync_q[SYNC_STAGES-1];
  assign cs_act   = ~cs_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev_q;
  assign cs_rise  = cs_act & ~cs_prev_q;
  assign word     = {dc_q, shift_q};

  always_comb begin
    sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
    dc_sync_d   = {dc_sync_q[SYNC_STAGES-2:0], spi_dc};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi_cs};
    sck_prev_d  = sck_s;
    cs_prev_d   = cs_act;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    dc_d    = dc_q;
    ferr_d  = 1'b0;
    push    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cs_rise) begin
          state_d = SHIFT;
          cnt_d   = '0;
          shift_d = '0;
        end
      end
      SHIFT: begin
        if (!cs_act) begin
          ferr_d  = (cnt_q != '0);
          state_d = IDLE;
        end else if (sck_rise) begin
          shift_d = {shift_q[SW-2:0], mosi_s};
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == CW'(SW - 1)) begin
            dc_d    = dc_s;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        push = 1'b1;
        if (cs_act) begin
          state_d = SHIFT;
          cnt_d   = '0;
          shift_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // cs_prev resets high so a CS already low at reset release is not a start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_sync_q  <= '0;
      mosi_sync_q <= '0;
      dc_sync_q   <= '0;
      cs_sync_q   <= '0;
      sck_prev_q  <= 1'b0;
      cs_prev_q   <= 1'b1;
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      dc_q        <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      sck_sync_q  <= sck_sync_d;
      mosi_sync_q <= mosi_sync_d;
      dc_sync_q   <= dc_sync_d;
      cs_sync_q   <= cs_sync_d;
      sck_prev_q  <= sck_prev_d;
      cs_prev_q   <= cs_prev_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      dc_q        <= dc_d;
      ferr_q      <= ferr_d;
    end
  end

  assign busy      = (state_q == SHIFT);
  assign frame_err = ferr_q;
  assign overflow  = ovf_q;

`ifdef SPI_SLAVE_RX_FIFO_EN
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int NW = $clog2(FIFO_DEPTH + 1);

  logic [DATA_SIZE-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_SIZE-1:0] mem_d [FIFO_DEPTH];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [NW-1:0] fcnt_q, fcnt_d;
  logic          push_ok;

  assign pop = (fcnt_q != '0) & rx.rx_ready;

  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    fcnt_d  = fcnt_q;
    ovf_d   = 1'b0;
    push_ok = 1'b0;
    if (pop) rd_d = rd_q + 1'b1;
    if (push) begin
      if (fcnt_q != NW'(FIFO_DEPTH) || pop) begin
        push_ok     = 1'b1;
        mem_d[wr_q] = word;
        wr_d        = wr_q + 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end
    unique case ({push_ok, pop})
      2'b10:   fcnt_d = fcnt_q + 1'b1;
      2'b01:   fcnt_d = fcnt_q - 1'b1;
      default: fcnt_d = fcnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      fcnt_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      mem_q  <= mem_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      fcnt_q <= fcnt_d;
      ovf_q  <= ovf_d;
    end
  end

  assign rx.rx_data  = mem_q[rd_q];
  assign rx.rx_valid = (fcnt_q != '0);
`else
  logic [DATA_SIZE-1:0] hold_q, hold_d;
  logic                 vld_q, vld_d;
  logic                 unused_depth;

  assign unused_depth = (FIFO_DEPTH > 0);
  assign pop = vld_q & rx.rx_ready;

  always_comb begin
    hold_d = hold_q;
    vld_d  = vld_q;
    ovf_d  = 1'b0;
    if (pop) vld_d = 1'b0;
    if (push) begin
      if (!vld_q || pop) begin
        hold_d = word;
        vld_d  = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q <= '0;
      vld_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      hold_q <= hold_d;
      vld_q  <= vld_d;
      ovf_q  <= ovf_d;
    end
  end

  assign rx.rx_data  = hold_q;
  assign rx.rx_valid = vld_q;
`endif
endmodule

// File: tb/tb_spi_slave_rx.sv
// Scoreboard bench for spi_slave_rx: directed SPI frames, queued
// expected words, negedge monitor popping on every accepted beat.
module tb_spi_slave_rx;
  localparam int DS   = 9;
  localparam int HALF = 40;
`ifdef SPI_SLAVE_RX_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  logic clk  = 1'b0;
  logic rst  = 1'b0;
  logic sck  = 1'b0;
  logic mosi = 1'b0;
  logic dc   = 1'b0;
  logic cs   = 1'b1;
  logic overflow, frame_err, busy;

  spi_slave_rx_if #(.DATA_SIZE(DS)) rx ();

  spi_slave_rx #(
    .DATA_SIZE  (DS),
    .SYNC_STAGES(2),
    .FIFO_DEPTH (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .spi_sck  (sck),
    .spi_mosi (mosi),
    .spi_dc   (dc),
    .spi_cs   (cs),
    .rx       (rx),
    .overflow (overflow),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  logic [DS-1:0] exp_q[$];
  logic [DS-1:0] mon_e;
  int tests = 0;
  int fails = 0;
  int beats = 0;
  int ovf_n = 0;
  int fe_n  = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (overflow) ovf_n++;
      if (frame_err) fe_n++;
      if (rx.rx_valid && rx.rx_ready) begin
        beats++;
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL word: got %h, required no word", rx.rx_data);
        end else begin
          mon_e = exp_q.pop_front();
          if (rx.rx_data !== mon_e) begin
            fails++;
            $display("FAIL word: got %h, required %h", rx.rx_data, mon_e);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic send_bits(input logic d, input logic [7:0] v, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      mosi = v[i];
      dc   = d;
      #HALF sck = 1'b1;
      #HALF sck = 1'b0;
    end
  endtask

  task automatic cs_on();
    cs = 1'b0;
    #HALF;
  endtask

  task automatic cs_off();
    #HALF;
    cs = 1'b1;
    #(4 * HALF);
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 rx.rx_ready = v;
  endtask

  task automatic drain(input string name);
    int k = 0;
    while (exp_q.size() != 0 && k < 300) begin
      @(posedge clk);
      k++;
    end
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, f0, o0;
    rx.rx_ready = 1'b0;
    #2 rst = 1'b1;
    #20;
    check("rst_valid", rx.rx_valid, 0);
    check("rst_data", rx.rx_data, 0);
    check("rst_busy", busy, 0);
    check("rst_ovf", overflow, 0);
    check("rst_ferr", frame_err, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    #(4 * HALF);

    // single command word
    set_ready(1'b1);
    b0 = beats;
    exp_q.push_back(9'h02A);
    cs_on();
    send_bits(1'b0, 8'h2A, 8);
    cs_off();
    drain("cmd_2a");
    check("cmd_beats", beats - b0, 1);

    // back-to-back data words under one CS
    f0 = fe_n;
    exp_q.push_back(9'h136);
    exp_q.push_back(9'h148);
    cs_on();
    send_bits(1'b1, 8'h36, 8);
    send_bits(1'b1, 8'h48, 8);
    cs_off();
    drain("b2b");
    check("b2b_ferr", fe_n - f0, 0);

    // CS drops mid-word
    f0 = fe_n;
    b0 = beats;
    cs_on();
    send_bits(1'b1, 8'hFF, 5);
    cs_off();
    check("ferr_pulse", fe_n - f0, 1);
    check("ferr_noword", beats - b0, 0);
    exp_q.push_back(9'h111);
    cs_on();
    send_bits(1'b1, 8'h11, 8);
    cs_off();
    drain("after_ferr");

    // six words with no consumer
    set_ready(1'b0);
    o0 = ovf_n;
    b0 = beats;
    cs_on();
    for (int w = 1; w <= 6; w++) send_bits(1'b1, 8'(w), 8);
    cs_off();
    check("ovf_count", ovf_n - o0, 6 - DEPTH);
    check("ovf_nopop", beats - b0, 0);
    for (int w = 1; w <= DEPTH; w++) exp_q.push_back({1'b1, 8'(w)});
    set_ready(1'b1);
    drain("retained");
    #(5 * HALF);
    check("retained_n", beats - b0, DEPTH);

    // pop coinciding with a push into a full output stage
    set_ready(1'b0);
    o0 = ovf_n;
    b0 = beats;
    cs_on();
    for (int w = 1; w <= DEPTH; w++) send_bits(1'b1, 8'(8'h40 + w), 8);
    cs_off();
    for (int w = 1; w <= DEPTH + 1; w++) exp_q.push_back({1'b1, 8'(8'h40 + w)});
    cs_on();
    fork
      send_bits(1'b1, 8'(8'h40 + DEPTH + 1), 8);
      begin
        int k = 0;
        @(posedge clk);
        #1;
        while (busy !== 1'b1 && k < 400) begin
          @(posedge clk);
          #1;
          k++;
        end
        while (busy === 1'b1 && k < 400) begin
          @(posedge clk);
          #1;
          k++;
        end
        check("done_seen", k < 400, 1);
        rx.rx_ready = 1'b1;
        @(posedge clk);
        #1 rx.rx_ready = 1'b0;
      end
    join
    cs_off();
    check("coinc_ovf", ovf_n - o0, 0);
    check("coinc_held", beats - b0, 1);
    set_ready(1'b1);
    drain("coinc_order");
    check("coinc_n", beats - b0, DEPTH + 1);

    // reset in the middle of a word
    set_ready(1'b0);
    f0 = fe_n;
    cs_on();
    send_bits(1'b1, 8'h77, 8);
    send_bits(1'b1, 8'hA5, 3);
    #(HALF / 2);
    check("pre_rst_valid", rx.rx_valid, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", rx.rx_valid, 0);
    check("mid_rst_data", rx.rx_data, 0);
    check("mid_rst_busy", busy, 0);
    #30 rst = 1'b0;
    #(2 * HALF);
    cs = 1'b1;
    #(4 * HALF);
    set_ready(1'b1);
    exp_q.push_back(9'h1A5);
    cs_on();
    send_bits(1'b1, 8'hA5, 8);
    cs_off();
    drain("post_rst");
    check("post_rst_ferr", fe_n - f0, 0);

    #(4 * HALF);
    check("final_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
